// File: rtl/u_byte_serializer_if.sv
// u_byte_serializer_if
// Word-in / byte-out stream bundle for the byte serializer.
//   in_valid/in_ready/in_word      : 16-bit word stream, [15:8] low byte, [7:0] high byte
//   out_valid/out_ready/out_byte   : byte stream
//   out_last                       : marks the second byte of a word
//   out_parity                     : XOR of out_byte (only with U_SER_PARITY_EN)
// Modports: master = word producer / byte consumer side, slave = serializer side.
interface u_byte_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
`ifdef U_SER_PARITY_EN
  logic        out_parity;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_parity
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_parity
  );
`else
  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
`endif
endinterface

// File: rtl/u_byte_serializer.sv
// u_byte_serializer
// Buffers 16-bit words in a DEPTH-entry FIFO and emits them one byte per
// cycle, tagging the second byte of each word with out_last.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   bus        : u_byte_serializer_if.slave (word in, byte out)
//   byte_count : bytes handed off since reset, wraps at 16 bits
//   fifo_level : words held in the FIFO (the word in the hold register is not counted)
// Parameters:
//   DEPTH      : FIFO depth in words, power of two, >= 2
//   LOW_FIRST  : 1 emits in_word[15:8] first, 0 emits in_word[7:0] first
// Optional build macro U_SER_PARITY_EN adds bus.out_parity = ^out_byte.
//
// state | meaning
// IDLE  | hold register empty, waiting for a FIFO word
// BYTE0 | presenting first byte of hold register
// BYTE1 | presenting second byte (out_last=1), pops next word on handoff
module u_byte_serializer #(
  parameter int DEPTH     = 2,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  u_byte_serializer_if.slave     bus,
  output logic [15:0]            byte_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   count_q, count_d;

  logic          in_ready_w;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          out_fire;
  logic          out_valid_w;
  logic          out_last_w;
  logic [7:0]    out_byte_w;

  // in_ready depends on the registered level only, never on out_ready.
  assign in_ready_w = (level_q != LW'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = bus.in_valid && in_ready_w;
  // Pops only see registered FIFO contents, so a word pushed this cycle
  // cannot bypass straight into the hold register.
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == BYTE1) && bus.out_ready));
  assign out_fire   = out_valid_w && bus.out_ready;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the level register alone defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= bus.in_word;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = BYTE0;
      BYTE0:   if (bus.out_ready) state_d = BYTE1;
      BYTE1:   if (bus.out_ready) state_d = fifo_empty ? IDLE : BYTE0;
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, level, hold register and byte counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    count_d  = count_q;

    // Pointer width equals log2(DEPTH), so the increment wraps by itself.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (out_fire) count_d = count_q + 16'd1;
  end

  // Output logic: decoded from registered state and hold register only,
  // so byte and tag stay put while the sink stalls.
  always_comb begin
    out_valid_w = 1'b0;
    out_last_w  = 1'b0;
    out_byte_w  = 8'h00;
    case (state_q)
      BYTE0: begin
        out_valid_w = 1'b1;
        out_byte_w  = LOW_FIRST ? hold_q[15:8] : hold_q[7:0];
      end
      BYTE1: begin
        out_valid_w = 1'b1;
        out_last_w  = 1'b1;
        out_byte_w  = LOW_FIRST ? hold_q[7:0] : hold_q[15:8];
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_last_w;
  assign bus.out_byte  = out_byte_w;
`ifdef U_SER_PARITY_EN
  assign bus.out_parity = ^out_byte_w;
`endif
  assign byte_count    = count_q;
  assign fifo_level    = level_q;

endmodule
